// File: rtl/sal_dq_turn_arb.sv
// DDR2 DQ bus read/write turnaround arbiter: tCCD spacing, tWTR/tRTW turnaround, write-drain watermarks.
// Optional starvation limiter enabled by defining SAL_ARB_STARVE_LIMIT_EN.
module sal_dq_turn_arb #(
  parameter int QCNT_W       = 4,
  parameter int WR_HI_WM     = 6,
  parameter int WR_LO_WM     = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [2:0]        t_ccd_i,
  input  logic [3:0]        t_wtr_i,
  input  logic [3:0]        t_rtw_i,
  input  logic              rd_req_i,
  input  logic              wr_req_i,
  input  logic              wr_data_rdy_i,
  input  logic [QCNT_W-1:0] wr_q_cnt_i,
  output logic              rd_gnt_o,
  output logic              wr_gnt_o,
  output logic [1:0]        mode_o,
  output logic [7:0]        turn_cnt_o
);

  typedef enum logic [1:0] {
    ST_RD  = 2'd0,
    ST_R2W = 2'd1,
    ST_WR  = 2'd2,
    ST_W2R = 2'd3
  } state_e;

  localparam logic [QCNT_W-1:0] HI_WM = QCNT_W'(WR_HI_WM);
  localparam logic [QCNT_W-1:0] LO_WM = QCNT_W'(WR_LO_WM);

  // The limit must fit the 8-bit burst counter.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 255) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be in 1..255");
  end

  state_e     state_q, state_d;
  logic [2:0] ccd_q, ccd_d;
  logic [3:0] wait_q, wait_d;
  logic [7:0] turn_q, turn_d;
  logic       rd_gnt, wr_gnt;
  logic       enter_turn;
  logic       starve_hit;
  logic       rd_switch, wr_switch;

`ifdef SAL_ARB_STARVE_LIMIT_EN
  localparam logic [7:0] STARVE_LIM8 = 8'(STARVE_LIMIT);
  logic [7:0] burst_q, burst_d;

  assign starve_hit = (burst_q >= STARVE_LIM8);

  always_comb begin
    burst_d = burst_q;
    if (enter_turn) begin
      burst_d = 8'd0;
    end else if ((rd_gnt || wr_gnt) && burst_q != 8'hFF) begin
      burst_d = burst_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      burst_q <= 8'd0;
    end else begin
      burst_q <= burst_d;
    end
  end
`else
  assign starve_hit = 1'b0;
`endif

  // Opposite request is always required; a forced switch never idles the bus.
  assign rd_switch = wr_req_i & (~rd_req_i | (wr_q_cnt_i >= HI_WM) | starve_hit);
  assign wr_switch = rd_req_i & (~wr_req_i | (wr_q_cnt_i <= LO_WM) | starve_hit);

  always_comb begin
    state_d    = state_q;
    wait_d     = wait_q;
    rd_gnt     = 1'b0;
    wr_gnt     = 1'b0;
    enter_turn = 1'b0;
    case (state_q)
      ST_RD: begin
        if (ccd_q == 3'd0) begin
          if (rd_switch) begin
            state_d    = ST_R2W;
            wait_d     = t_rtw_i;
            enter_turn = 1'b1;
          end else if (rd_req_i) begin
            rd_gnt = 1'b1;
          end
        end
      end
      ST_WR: begin
        if (ccd_q == 3'd0) begin
          if (wr_switch) begin
            state_d    = ST_W2R;
            wait_d     = t_wtr_i;
            enter_turn = 1'b1;
          end else if (wr_req_i && wr_data_rdy_i) begin
            wr_gnt = 1'b1;
          end
        end
      end
      ST_R2W: begin
        if (wait_q == 4'd0) begin
          state_d = ST_WR;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
      default: begin
        if (wait_q == 4'd0) begin
          state_d = ST_RD;
        end else begin
          wait_d = wait_q - 4'd1;
        end
      end
    endcase
  end

  always_comb begin
    ccd_d = (ccd_q != 3'd0) ? ccd_q - 3'd1 : 3'd0;
    if (rd_gnt || wr_gnt) begin
      ccd_d = t_ccd_i - 3'd1;
    end
    turn_d = turn_q;
    if (enter_turn && turn_q != 8'hFF) begin
      turn_d = turn_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_RD;
      ccd_q   <= 3'd0;
      wait_q  <= 4'd0;
      turn_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      ccd_q   <= ccd_d;
      wait_q  <= wait_d;
      turn_q  <= turn_d;
    end
  end

  assign rd_gnt_o   = rst_n & rd_gnt;
  assign wr_gnt_o   = rst_n & wr_gnt;
  assign mode_o     = state_q;
  assign turn_cnt_o = turn_q;

endmodule

// File: tb/tb_sal_dq_turn_arb.sv
// Bench for sal_dq_turn_arb: directed vector table, starvation sequence, randomized run vs. reference model.
module tb_sal_dq_turn_arb;

  localparam int SL = 4;
  localparam int HI = 6;
  localparam int LO = 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] t_ccd_i;
  logic [3:0] t_wtr_i, t_rtw_i;
  logic       rd_req_i, wr_req_i, wr_data_rdy_i;
  logic [3:0] wr_q_cnt_i;
  logic       rd_gnt_o, wr_gnt_o;
  logic [1:0] mode_o;
  logic [7:0] turn_cnt_o;

  int total = 0;
  int bad   = 0;

  sal_dq_turn_arb #(
    .QCNT_W(4), .WR_HI_WM(HI), .WR_LO_WM(LO), .STARVE_LIMIT(SL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .t_ccd_i(t_ccd_i), .t_wtr_i(t_wtr_i), .t_rtw_i(t_rtw_i),
    .rd_req_i(rd_req_i), .wr_req_i(wr_req_i), .wr_data_rdy_i(wr_data_rdy_i),
    .wr_q_cnt_i(wr_q_cnt_i), .rd_gnt_o(rd_gnt_o), .wr_gnt_o(wr_gnt_o),
    .mode_o(mode_o), .turn_cnt_o(turn_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       rd, wr, rdy;
    logic [3:0] q;
    logic [2:0] tccd;
    logic [3:0] twtr, trtw;
    logic       erd, ewr;
    logic [1:0] emode;
    logic [7:0] eturn;
  } vec_t;

  vec_t vecs [30];

  function automatic vec_t mk(input logic rst, rd, wr, rdy, input int q, tccd, twtr, trtw,
                              input logic erd, ewr, input int emode, eturn);
    vec_t v;
    v.rst = rst; v.rd = rd; v.wr = wr; v.rdy = rdy;
    v.q = 4'(q); v.tccd = 3'(tccd); v.twtr = 4'(twtr); v.trtw = 4'(trtw);
    v.erd = erd; v.ewr = ewr; v.emode = 2'(emode); v.eturn = 8'(eturn);
    return v;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rst, rd, wr, rdy, input logic [3:0] q,
                       input logic [2:0] tccd, input logic [3:0] twtr, trtw);
    rst_n = rst; rd_req_i = rd; wr_req_i = wr; wr_data_rdy_i = rdy;
    wr_q_cnt_i = q; t_ccd_i = tccd; t_wtr_i = twtr; t_rtw_i = trtw;
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 3'd1, 4'd0, 4'd0);
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
  endtask

  // Reference: bus direction, whether a turnaround is in flight, and cycles until next grant.
  int  m_side, m_turning, m_left, m_gap, m_turns, m_burst;
  int  n_side, n_turning, n_left, n_gap, n_turns, n_burst;
  int  m_rd, m_wr, m_mode;

  task automatic model_eval();
    int mine, other, press, starve, leave;
    m_rd = 0; m_wr = 0;
    m_mode = m_turning ? (m_side ? 1 : 3) : (m_side ? 2 : 0);
    n_side = m_side; n_turning = m_turning; n_left = m_left;
    n_turns = m_turns; n_burst = m_burst;
    if (!rst_n) begin
      n_side = 0; n_turning = 0; n_left = 0; n_gap = 0; n_turns = 0; n_burst = 0;
      return;
    end
    if (m_turning == 0) begin
      mine  = m_side ? int'(wr_req_i) : int'(rd_req_i);
      other = m_side ? int'(rd_req_i) : int'(wr_req_i);
      press = m_side ? int'(wr_q_cnt_i <= 4'(LO)) : int'(wr_q_cnt_i >= 4'(HI));
`ifdef SAL_ARB_STARVE_LIMIT_EN
      starve = int'(m_burst >= SL);
`else
      starve = 0;
`endif
      leave = int'(other != 0 && (mine == 0 || press != 0 || starve != 0));
      if (m_gap == 0 && leave != 0) begin
        n_turning = 1;
        n_side    = 1 - m_side;
        n_left    = n_side ? int'(t_rtw_i) : int'(t_wtr_i);
        n_turns   = (m_turns < 255) ? m_turns + 1 : 255;
        n_burst   = 0;
      end else if (m_gap == 0 && mine != 0 && (m_side == 0 || wr_data_rdy_i)) begin
        if (m_side != 0) m_wr = 1; else m_rd = 1;
      end
    end else if (m_left == 0) begin
      n_turning = 0;
    end else begin
      n_left = m_left - 1;
    end
    if (m_rd != 0 || m_wr != 0) begin
      n_gap   = int'(t_ccd_i) - 1;
      n_burst = (m_burst < 255) ? m_burst + 1 : 255;
    end else begin
      n_gap = (m_gap > 0) ? m_gap - 1 : 0;
    end
  endtask

  task automatic model_commit();
    m_side = n_side; m_turning = n_turning; m_left = n_left;
    m_gap = n_gap; m_turns = n_turns; m_burst = n_burst;
  endtask

  initial begin
    int rd_cnt;
    int last_mode;
    logic [2:0] r_tccd;
    logic [3:0] r_twtr, r_trtw;

    vecs[0]  = mk(0,1,0,1,0,2,2,3, 0,0,0,0);
    vecs[1]  = mk(1,1,0,1,0,2,2,3, 1,0,0,0);
    vecs[2]  = mk(1,1,0,1,0,2,2,3, 0,0,0,0);
    vecs[3]  = mk(1,1,0,1,0,2,2,3, 1,0,0,0);
    vecs[4]  = mk(1,1,0,1,0,2,2,3, 0,0,0,0);
    vecs[5]  = mk(1,1,1,1,6,2,2,3, 0,0,0,0);
    vecs[6]  = mk(1,1,1,1,6,2,2,3, 0,0,1,1);
    vecs[7]  = mk(1,1,1,1,6,2,2,3, 0,0,1,1);
    vecs[8]  = mk(1,1,1,1,6,2,2,3, 0,0,1,1);
    vecs[9]  = mk(1,1,1,1,6,2,2,3, 0,0,1,1);
    vecs[10] = mk(1,1,1,1,6,2,2,3, 0,1,2,1);
    vecs[11] = mk(1,1,1,1,3,2,2,3, 0,0,2,1);
    vecs[12] = mk(1,1,1,1,3,2,2,3, 0,1,2,1);
    vecs[13] = mk(1,1,1,1,1,2,2,3, 0,0,2,1);
    vecs[14] = mk(1,1,1,1,1,2,2,3, 0,0,2,1);
    vecs[15] = mk(1,1,1,1,1,2,2,3, 0,0,3,2);
    vecs[16] = mk(1,1,1,1,1,2,2,3, 0,0,3,2);
    vecs[17] = mk(1,1,1,1,1,2,2,3, 0,0,3,2);
    vecs[18] = mk(1,1,1,1,1,2,2,3, 1,0,0,2);
    vecs[19] = mk(1,0,1,1,1,2,2,3, 0,0,0,2);
    vecs[20] = mk(1,0,1,1,1,2,2,0, 0,0,0,2);
    vecs[21] = mk(1,0,1,0,1,2,2,0, 0,0,1,3);
    vecs[22] = mk(1,0,1,0,1,2,2,0, 0,0,2,3);
    vecs[23] = mk(1,0,1,0,1,2,2,0, 0,0,2,3);
    vecs[24] = mk(1,0,1,1,1,2,2,0, 0,1,2,3);
    vecs[25] = mk(1,1,0,1,1,2,2,0, 0,0,2,3);
    vecs[26] = mk(1,1,0,1,1,2,5,0, 0,0,2,3);
    vecs[27] = mk(0,1,0,1,1,2,5,0, 0,0,3,4);
    vecs[28] = mk(1,1,0,1,1,2,5,0, 1,0,0,0);
    vecs[29] = mk(1,1,0,1,1,2,5,0, 0,0,0,0);

    do_reset();
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].rd, vecs[i].wr, vecs[i].rdy, vecs[i].q,
            vecs[i].tccd, vecs[i].twtr, vecs[i].trtw);
      #1;
      $display("vec %0d: rst_n=%0b rd=%0b wr=%0b rdy=%0b q=%0d -> rd_gnt=%0b wr_gnt=%0b mode=%0d turn=%0d",
               i, rst_n, rd_req_i, wr_req_i, wr_data_rdy_i, wr_q_cnt_i,
               rd_gnt_o, wr_gnt_o, mode_o, turn_cnt_o);
      chk($sformatf("vec%0d_rd_gnt", i), int'(rd_gnt_o), int'(vecs[i].erd));
      chk($sformatf("vec%0d_wr_gnt", i), int'(wr_gnt_o), int'(vecs[i].ewr));
      chk($sformatf("vec%0d_mode", i),   int'(mode_o),   int'(vecs[i].emode));
      chk($sformatf("vec%0d_turn", i),   int'(turn_cnt_o), int'(vecs[i].eturn));
      @(posedge clk);
    end

    // Both sides held with writes below the high watermark: only the starvation limiter can switch.
    do_reset();
    rd_cnt = 0;
    last_mode = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(1'b1, 1'b1, 1'b1, 1'b1, 4'd3, 3'd1, 4'd0, 4'd0);
      #1;
      $display("starve %0d: rd_gnt=%0b wr_gnt=%0b mode=%0d", i, rd_gnt_o, wr_gnt_o, mode_o);
      rd_cnt += int'(rd_gnt_o);
      last_mode = int'(mode_o);
      @(posedge clk);
    end
`ifdef SAL_ARB_STARVE_LIMIT_EN
    chk("starve_rd_count", rd_cnt, SL);
    chk("starve_final_mode", last_mode, 2);
`else
    chk("starve_rd_count", rd_cnt, 10);
    chk("starve_final_mode", last_mode, 0);
`endif

    // Randomized run against the reference model.
    do_reset();
    m_side = 0; m_turning = 0; m_left = 0; m_gap = 0; m_turns = 0; m_burst = 0;
    r_tccd = 3'd2; r_twtr = 4'd3; r_trtw = 4'd2;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      if ($urandom_range(0, 39) == 0) r_tccd = 3'($urandom_range(1, 7));
      if ($urandom_range(0, 39) == 0) r_twtr = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 39) == 0) r_trtw = 4'($urandom_range(0, 15));
      drive(($urandom_range(0, 99) != 0), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), r_tccd, r_twtr, r_trtw);
      #1;
      model_eval();
      $display("rnd %0d: rst_n=%0b rd=%0b wr=%0b rdy=%0b q=%0d -> rd_gnt=%0b wr_gnt=%0b mode=%0d turn=%0d",
               i, rst_n, rd_req_i, wr_req_i, wr_data_rdy_i, wr_q_cnt_i,
               rd_gnt_o, wr_gnt_o, mode_o, turn_cnt_o);
      chk("rnd_rd_gnt", int'(rd_gnt_o), m_rd);
      chk("rnd_wr_gnt", int'(wr_gnt_o), m_wr);
      chk("rnd_mode", int'(mode_o), m_mode);
      chk("rnd_turn", int'(turn_cnt_o), m_turns);
      @(posedge clk);
      model_commit();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
